hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Generates the stall/flush/bubble controls consumed by the FD, DX and XM pipeline registers and by the PC.
//  Sources: load-use hazards (DX load feeding an FD source), taken-branch redirects from execute, data-memory wait.
//  Small FSM sequences multi-cycle events; saturating counters report stall/flush activity.
//  Sits beside the pipeline registers in the core top level.
// PARAMETERS
//  REG_W       5   register address width
//  MEM_TIMEOUT 16  consecutive mem_busy_i cycles before mem_timeout_o is set
//  CNT_W       32  width of stall_cnt_o / flush_cnt_o
// PORTS
//  clk             in  1      core clock
//  reset           in  1      synchronous, active-high reset
//  fd_rs_addr_i    in  REG_W  rs address of the instruction in FD
//  fd_rd_addr_i    in  REG_W  rd address of the instruction in FD
//  fd_reads_rs_i   in  1      FD instruction reads rs
//  fd_reads_rd_i   in  1      FD instruction reads rd as a source
//  dx_rd_addr_i    in  REG_W  destination address of the instruction in DX
//  dx_is_load_op_i in  1      DX instruction is a load
//  x_branch_taken_i in 1      execute resolved a taken branch/jump this cycle
//  mem_busy_i      in  1      data memory not ready; M stage must hold
//  stall_pc_o      out 1      hold PC
//  stall_fd_o      out 1      hold FD register
//  stall_dx_o      out 1      hold DX register
//  stall_xm_o      out 1      hold XM register
//  bubble_dx_o     out 1      load kNOP into DX
//  flush_fd_o      out 1      load kNOP into FD
//  flush_dx_o      out 1      load kNOP into DX
//  mem_timeout_o   out 1      sticky: memory wait exceeded MEM_TIMEOUT
//  stall_cnt_o     out CNT_W  cycles with stall_pc_o=1, saturating
//  flush_cnt_o     out CNT_W  cycles with flush_fd_o=1 outside reset, saturating
// BEHAVIOUR
//  - Control outputs are combinational from state + current inputs; they act at the next clk edge (0-cycle latency).
//  - FSM states: RUN, LU_BUBBLE, MEM_WAIT, REDIRECT. Reset -> RUN.
//  - lu_hit = dx_is_load_op_i & ((fd_reads_rs_i & rs==dx_rd) | (fd_reads_rd_i & rd==dx_rd)). Address 0 is not special.
//  - Priority per cycle: reset > mem_busy_i > x_branch_taken_i > lu_hit.
//  - mem_busy_i=1 in any state: stall_pc/fd/dx/xm=1, no flush/bubble.
//    Next state is MEM_WAIT; wait_cnt increments.
//    When wait_cnt reaches MEM_TIMEOUT-1 with mem_busy_i still 1, mem_timeout_o sets and stays set until reset; stalling continues.
//  - MEM_WAIT with mem_busy_i=0: wait_cnt clears; the remaining rules are evaluated as in RUN this same cycle.
//    A branch held in DX during the wait flushes on release.
//  - x_branch_taken_i=1 (no mem_busy_i): flush_fd=flush_dx=1, no stalls; next REDIRECT.
//  - REDIRECT (1 cycle): lu_hit and x_branch_taken_i are ignored (DX holds kNOP); next RUN unless mem_busy_i=1.
//  - lu_hit in RUN (no higher-priority event): stall_pc=stall_fd=1, bubble_dx=1; next LU_BUBBLE.
//  - LU_BUBBLE (1 cycle): lu_hit is masked, so the bubble is exactly one cycle.
//    Outputs are 0 unless mem_busy_i/x_branch_taken_i apply; next RUN.
//  - bubble_dx_o and flush_dx_o are never both 1. stall_xm_o=1 only in a mem wait.
//  - While reset=1: flush_fd_o=flush_dx_o=1, all stalls and bubble 0, so pipeline registers fill with kNOP.
//    Counters, wait_cnt and mem_timeout_o clear at the edge; state returns to RUN even mid-wait or mid-bubble.
//  - Counters saturate at 2**CNT_W-1; no wrap.
// TESTING
//  - Load r3 in DX, FD reads rs=r3: one cycle stall_pc=stall_fd=bubble_dx=1, then all 0 with the same FD inputs held; stall_cnt=1.
//  - lu_hit and x_branch_taken_i in the same cycle: flush_fd=flush_dx=1, bubble_dx=0; next cycle (REDIRECT) all 0; flush_cnt=1.
//  - mem_busy_i high 3 cycles with branch_taken held: 3 cycles of all four stalls, no flush; branch flush on the 4th cycle.
//  - mem_busy_i high 16 cycles (MEM_TIMEOUT=16): mem_timeout_o rises after the 16th, stays 1 after busy drops, clears only on reset.
//  - Reset asserted mid MEM_WAIT: flush_fd/dx=1, stalls 0 during reset; after release state RUN, counters 0, timeout 0.
//  - Force stall_cnt to max-1, run 3 stall cycles: stall_cnt holds at 2**CNT_W-1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Stall / flush / bubble control for the FD, DX and XM pipeline registers
//   and the PC. Handles load-use hazards (DX load feeding an FD source),
//   taken-branch redirects from execute and data-memory wait. A small FSM
//   sequences the multi-cycle events; two saturating counters report
//   stall and flush activity.
//
//   All control outputs are combinational from the current state and
//   inputs and take effect at the next clk edge.
//
// Ports
//   clk, reset            core clock, synchronous active-high reset
//   fd_rs_addr_i          rs address of the FD instruction
//   fd_rd_addr_i          rd address of the FD instruction
//   fd_reads_rs_i         FD instruction reads rs
//   fd_reads_rd_i         FD instruction reads rd as a source
//   dx_rd_addr_i          destination address of the DX instruction
//   dx_is_load_op_i       DX instruction is a load
//   x_branch_taken_i      execute resolved a taken branch/jump
//   mem_busy_i            data memory not ready, M stage holds
//   stall_pc_o..stall_xm_o  hold PC / FD / DX / XM
//   bubble_dx_o           load kNOP into DX (load-use bubble)
//   flush_fd_o/flush_dx_o load kNOP into FD / DX
//   mem_timeout_o         sticky: memory wait exceeded MEM_TIMEOUT cycles
//   stall_cnt_o           cycles with stall_pc_o=1, saturating
//   flush_cnt_o           cycles with flush_fd_o=1 outside reset, saturating
//   fsm_state             current FSM state (debug)
//
// Handshake: there is no valid/ready pair; every output is level-valid in
// every cycle and is consumed by the pipeline registers at the next edge.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REG_W       = 5,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] fd_rs_addr_i,
   input  logic [REG_W-1:0] fd_rd_addr_i,
   input  logic             fd_reads_rs_i,
   input  logic             fd_reads_rd_i,
   input  logic [REG_W-1:0] dx_rd_addr_i,
   input  logic             dx_is_load_op_i,
   input  logic             x_branch_taken_i,
   input  logic             mem_busy_i,
   output logic             stall_pc_o,
   output logic             stall_fd_o,
   output logic             stall_dx_o,
   output logic             stall_xm_o,
   output logic             bubble_dx_o,
   output logic             flush_fd_o,
   output logic             flush_dx_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [1:0]       fsm_state
);

   localparam logic [1:0] RUN       = 2'd0;
   localparam logic [1:0] LU_BUBBLE = 2'd1;
   localparam logic [1:0] MEM_WAIT  = 2'd2;
   localparam logic [1:0] REDIRECT  = 2'd3;

   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              lu_hit;

   // Address 0 is treated like any other register.
   assign lu_hit = dx_is_load_op_i &
                   ((fd_reads_rs_i & (fd_rs_addr_i == dx_rd_addr_i)) |
                    (fd_reads_rd_i & (fd_rd_addr_i == dx_rd_addr_i)));

   assign fsm_state = state;

   // Priority: reset > mem_busy > branch > load-use.
   // REDIRECT ignores branch and lu_hit because DX already holds kNOP;
   // LU_BUBBLE masks lu_hit so the bubble lasts exactly one cycle.
   always_comb begin
      stall_pc_o  = 1'b0;
      stall_fd_o  = 1'b0;
      stall_dx_o  = 1'b0;
      stall_xm_o  = 1'b0;
      bubble_dx_o = 1'b0;
      flush_fd_o  = 1'b0;
      flush_dx_o  = 1'b0;
      state_next  = RUN;
      if (reset) begin
         // Fill FD and DX with kNOP while reset is held.
         flush_fd_o = 1'b1;
         flush_dx_o = 1'b1;
      end else if (mem_busy_i) begin
         stall_pc_o = 1'b1;
         stall_fd_o = 1'b1;
         stall_dx_o = 1'b1;
         stall_xm_o = 1'b1;
         state_next = MEM_WAIT;
      end else if ((state != REDIRECT) && x_branch_taken_i) begin
         flush_fd_o = 1'b1;
         flush_dx_o = 1'b1;
         state_next = REDIRECT;
      end else if ((state != REDIRECT) && (state != LU_BUBBLE) && lu_hit) begin
         stall_pc_o  = 1'b1;
         stall_fd_o  = 1'b1;
         bubble_dx_o = 1'b1;
         state_next  = LU_BUBBLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         wait_cnt      <= '0;
         mem_timeout_o <= 1'b0;
         stall_cnt_o   <= '0;
         flush_cnt_o   <= '0;
      end else begin
         state <= state_next;

         // wait_cnt counts consecutive busy cycles; it parks at WAIT_LAST
         // once the timeout fires so it cannot wrap during a long wait.
         if (mem_busy_i) begin
            if (wait_cnt == WAIT_LAST) begin
               mem_timeout_o <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + WAIT_W'(1);
            end
         end else begin
            wait_cnt <= '0;
         end

         if (stall_pc_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         end
         if (flush_fd_o && (flush_cnt_o != {CNT_W{1'b1}})) begin
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. The driver applies one row per cycle
//   and pushes the hand-computed expected output vector; a monitor on the
//   falling edge pops and compares. A second instance with CNT_W=2 checks
//   counter saturation.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam logic [1:0] S_RUN = 2'd0;
   localparam logic [1:0] S_LB  = 2'd1;
   localparam logic [1:0] S_MW  = 2'd2;
   localparam logic [1:0] S_RD  = 2'd3;

   // {stall_pc, stall_fd, stall_dx, stall_xm, bubble_dx, flush_fd, flush_dx}
   localparam logic [6:0] C_NONE  = 7'b0000000;
   localparam logic [6:0] C_LU    = 7'b1100100;
   localparam logic [6:0] C_STALL = 7'b1111000;
   localparam logic [6:0] C_FLUSH = 7'b0000011;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // ---------------- main DUT ----------------
   logic [4:0]  fd_rs_addr, fd_rd_addr, dx_rd_addr;
   logic        fd_reads_rs, fd_reads_rd, dx_is_load, br_taken, mem_busy;
   logic        stall_pc, stall_fd, stall_dx, stall_xm, bubble_dx;
   logic        flush_fd, flush_dx, mem_timeout;
   logic [31:0] stall_cnt, flush_cnt;
   logic [1:0]  fsm_state;

   hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .fd_rs_addr_i(fd_rs_addr), .fd_rd_addr_i(fd_rd_addr),
      .fd_reads_rs_i(fd_reads_rs), .fd_reads_rd_i(fd_reads_rd),
      .dx_rd_addr_i(dx_rd_addr), .dx_is_load_op_i(dx_is_load),
      .x_branch_taken_i(br_taken), .mem_busy_i(mem_busy),
      .stall_pc_o(stall_pc), .stall_fd_o(stall_fd), .stall_dx_o(stall_dx),
      .stall_xm_o(stall_xm), .bubble_dx_o(bubble_dx),
      .flush_fd_o(flush_fd), .flush_dx_o(flush_dx),
      .mem_timeout_o(mem_timeout), .stall_cnt_o(stall_cnt),
      .flush_cnt_o(flush_cnt), .fsm_state(fsm_state)
   );

   // ---------------- saturation DUT (CNT_W=2) ----------------
   logic [4:0] s_addr = 5'd0;
   logic       s_zero = 1'b0;
   logic       s_busy;
   logic       s_spc, s_sfd, s_sdx, s_sxm, s_bub, s_ffd, s_fdx, s_to;
   logic [1:0] s_stall_cnt, s_flush_cnt, s_state;

   hazard_ctrl #(.REG_W(5), .MEM_TIMEOUT(16), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset),
      .fd_rs_addr_i(s_addr), .fd_rd_addr_i(s_addr),
      .fd_reads_rs_i(s_zero), .fd_reads_rd_i(s_zero),
      .dx_rd_addr_i(s_addr), .dx_is_load_op_i(s_zero),
      .x_branch_taken_i(s_zero), .mem_busy_i(s_busy),
      .stall_pc_o(s_spc), .stall_fd_o(s_sfd), .stall_dx_o(s_sdx),
      .stall_xm_o(s_sxm), .bubble_dx_o(s_bub),
      .flush_fd_o(s_ffd), .flush_dx_o(s_fdx),
      .mem_timeout_o(s_to), .stall_cnt_o(s_stall_cnt),
      .flush_cnt_o(s_flush_cnt), .fsm_state(s_state)
   );

   // ---------------- scoreboard ----------------
   logic [73:0] exp_q[$];
   string       name_q[$];
   logic [1:0]  sat_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [73:0] e, a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {fsm_state, stall_pc, stall_fd, stall_dx, stall_xm, bubble_dx,
               flush_fd, flush_dx, mem_timeout, stall_cnt, flush_cnt};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ctl=%b to=%b sc=%0d fc=%0d expected st=%0d ctl=%b to=%b sc=%0d fc=%0d",
                     nm, a[73:72], a[71:65], a[64], a[63:32], a[31:0],
                     e[73:72], e[71:65], e[64], e[63:32], e[31:0]);
         end
      end
      if (sat_q.size() > 0) begin
         logic [1:0] es;
         es = sat_q.pop_front();
         n_checks++;
         if (s_stall_cnt !== es) begin
            n_fail++;
            $display("FAIL sat_stall_cnt: got %0d expected %0d", s_stall_cnt, es);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [4:0] rs, input logic rrs,
                        input logic [4:0] rd, input logic rrd, input logic [4:0] dxrd,
                        input logic ld, input logic br, input logic busy);
      reset       = r;
      fd_rs_addr  = rs;
      fd_reads_rs = rrs;
      fd_rd_addr  = rd;
      fd_reads_rd = rrd;
      dx_rd_addr  = dxrd;
      dx_is_load  = ld;
      br_taken    = br;
      mem_busy    = busy;
   endtask

   task automatic expect_main(input string nm, input logic [1:0] st, input logic [6:0] ctl,
                              input logic to, input int sc, input int fc);
      exp_q.push_back({st, ctl, to, sc[31:0], fc[31:0]});
      name_q.push_back(nm);
   endtask

   // One checked cycle on the main DUT.
   task automatic row(input string nm, input logic r, input logic [4:0] rs, input logic rrs,
                      input logic [4:0] rd, input logic rrd, input logic [4:0] dxrd,
                      input logic ld, input logic br, input logic busy,
                      input logic [1:0] st, input logic [6:0] ctl, input logic to,
                      input int sc, input int fc);
      drive(r, rs, rrs, rd, rrd, dxrd, ld, br, busy);
      expect_main(nm, st, ctl, to, sc, fc);
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      s_busy = 1'b0;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      //   name              r rs rrs rd rrd dx ld br bz  state  ctrl    to sc  fc
      row("reset",           1, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN, C_FLUSH, 0, 0, 0);
      row("idle",            0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN, C_NONE,  0, 0, 0);
      row("lu_rs",           0, 3, 1, 0, 0, 3, 1, 0, 0, S_RUN, C_LU,    0, 0, 0);
      row("lu_rs_hold",      0, 3, 1, 0, 0, 3, 1, 0, 0, S_LB,  C_NONE,  0, 1, 0);
      row("lu_rd",           0, 3, 0, 7, 1, 7, 1, 0, 0, S_RUN, C_LU,    0, 1, 0);
      row("lu_rd_hold",      0, 3, 0, 7, 1, 7, 1, 0, 0, S_LB,  C_NONE,  0, 2, 0);
      row("no_load",         0, 3, 1, 0, 0, 3, 0, 0, 0, S_RUN, C_NONE,  0, 2, 0);
      row("lu_and_br",       0, 3, 1, 0, 0, 3, 1, 1, 0, S_RUN, C_FLUSH, 0, 2, 0);
      row("redirect_ign",    0, 3, 1, 0, 0, 3, 1, 1, 0, S_RD,  C_NONE,  0, 2, 1);
      row("idle2",           0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN, C_NONE,  0, 2, 1);
      for (int i = 0; i < 3; i++)
         row("busy_br",      0, 0, 0, 0, 0, 0, 0, 1, 1, (i == 0) ? S_RUN : S_MW,
             C_STALL, 0, 2 + i, 1);
      row("br_release",      0, 0, 0, 0, 0, 0, 0, 1, 0, S_MW,  C_FLUSH, 0, 5, 1);
      row("after_release",   0, 0, 0, 0, 0, 0, 0, 0, 0, S_RD,  C_NONE,  0, 5, 2);
      for (int i = 0; i < 16; i++)
         row("busy16",       0, 0, 0, 0, 0, 0, 0, 0, 1, (i == 0) ? S_RUN : S_MW,
             C_STALL, 0, 5 + i, 2);
      row("timeout_set",     0, 0, 0, 0, 0, 0, 0, 0, 0, S_MW,  C_NONE,  1, 21, 2);
      row("timeout_sticky",  0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN, C_NONE,  1, 21, 2);
      row("busy_again",      0, 0, 0, 0, 0, 0, 0, 0, 1, S_RUN, C_STALL, 1, 21, 2);
      row("rst_mid_wait",    1, 0, 0, 0, 0, 0, 0, 0, 1, S_MW,  C_FLUSH, 1, 22, 2);
      row("post_rst",        0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN, C_NONE,  0, 0, 0);
      row("lu_again",        0, 3, 1, 0, 0, 3, 1, 0, 0, S_RUN, C_LU,    0, 0, 0);
      row("rst_mid_bubble",  1, 3, 1, 0, 0, 3, 1, 0, 0, S_LB,  C_FLUSH, 0, 1, 0);
      row("post_rst_lu",     0, 3, 1, 0, 0, 3, 1, 0, 0, S_RUN, C_LU,    0, 0, 0);
      row("bubble_busy",     0, 0, 0, 0, 0, 0, 0, 0, 1, S_LB,  C_STALL, 0, 1, 0);
      row("wait_release",    0, 0, 0, 0, 0, 0, 0, 0, 0, S_MW,  C_NONE,  0, 2, 0);
      row("idle3",           0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN, C_NONE,  0, 2, 0);
      row("lu_pre_br",       0, 3, 1, 0, 0, 3, 1, 0, 0, S_RUN, C_LU,    0, 2, 0);
      row("bubble_br",       0, 3, 1, 0, 0, 3, 1, 1, 0, S_LB,  C_FLUSH, 0, 3, 0);
      row("redirect_lu",     0, 3, 1, 0, 0, 3, 1, 0, 0, S_RD,  C_NONE,  0, 3, 1);
      row("run_lu",          0, 3, 1, 0, 0, 3, 1, 0, 0, S_RUN, C_LU,    0, 3, 1);
      row("idle4",           0, 0, 0, 0, 0, 0, 0, 0, 0, S_LB,  C_NONE,  0, 4, 1);
      row("br_only",         0, 0, 0, 0, 0, 0, 0, 1, 0, S_RUN, C_FLUSH, 0, 4, 1);
      row("redirect_busy",   0, 0, 0, 0, 0, 0, 0, 0, 1, S_RD,  C_STALL, 0, 4, 2);
      row("wait_release2",   0, 0, 0, 0, 0, 0, 0, 0, 0, S_MW,  C_NONE,  0, 5, 2);
      row("idle5",           0, 0, 0, 0, 0, 0, 0, 0, 0, S_RUN, C_NONE,  0, 5, 2);
      row("addr0_hit",       0, 0, 1, 0, 0, 0, 1, 0, 0, S_RUN, C_LU,    0, 5, 2);
      row("idle6",           0, 0, 0, 0, 0, 0, 0, 0, 0, S_LB,  C_NONE,  0, 6, 2);
      row("no_read_flags",   0, 0, 0, 0, 0, 0, 1, 0, 0, S_RUN, C_NONE,  0, 6, 2);

      // Saturation: 2-bit stall counter reaches 2 (max-1), then holds at 3.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         s_busy = 1'b1;
         sat_q.push_back((i < 3) ? 2'(i) : 2'd3);
         tick();
      end
      s_busy = 1'b0;
      sat_q.push_back(2'd3);
      tick();

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() + sat_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size() + sat_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
